// File: rtl/counter_disp.sv
// Multi-digit decimal overlay: converts a binary value to BCD with a sequential
// shift-add-3 engine and draws the digits as seven-segment glyphs.

module counter_disp #(
    parameter logic [9:0]  H_POS        = 10'd40,
    parameter logic [9:0]  V_POS        = 10'd80,
    parameter int unsigned DIGITS       = 2,
    parameter int unsigned VAL_W        = 8,
    parameter logic [9:0]  DIGIT_PITCH  = 10'd20,
    parameter logic [23:0] COLOR        = 24'h00ff00,
    parameter logic [23:0] FLASH_COLOR  = 24'hffffff,
    parameter int unsigned FLASH_FRAMES = 32,
    parameter bit          BLANK_LZ     = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [VAL_W-1:0] value,
    input  logic             frame_tick,
    input  logic [9:0]       hcounter,
    input  logic [9:0]       vcounter,
    output logic             busy,
    output logic             visible,
    output logic [23:0]      rgb
);

    localparam int unsigned BCD_W   = 4 * DIGITS;
    localparam int unsigned MAX_VAL = 10 ** DIGITS - 1;
    localparam int unsigned CNT_W   = (VAL_W < 2) ? 1 : $clog2(VAL_W + 1);
    localparam int unsigned FL_RAW  = $clog2(FLASH_FRAMES + 1);
    // Keep at least 3 bits so the blink bit always exists.
    localparam int unsigned FL_W    = (FL_RAW < 3) ? 3 : FL_RAW;

    typedef enum logic [1:0] {StIdle, StConv, StCommit} state_e;

    state_e             state_q, state_d;
    logic [VAL_W-1:0]   shown_bin_q, shown_bin_d;
    logic [VAL_W-1:0]   snap_q, snap_d;
    logic               sat_q, sat_d;
    logic [BCD_W-1:0]   disp_q, disp_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
    logic [FL_W-1:0]    flash_cnt_q, flash_cnt_d;

    logic [BCD_W-1:0]   bcd_adj;
    logic               in_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            shown_bin_q <= '0;
            snap_q      <= '0;
            sat_q       <= 1'b0;
            disp_q      <= '0;
            bcd_q       <= '0;
            bitcnt_q    <= '0;
            flash_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            shown_bin_q <= shown_bin_d;
            snap_q      <= snap_d;
            sat_q       <= sat_d;
            disp_q      <= disp_d;
            bcd_q       <= bcd_d;
            bitcnt_q    <= bitcnt_d;
            flash_cnt_q <= flash_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shown_bin_d = shown_bin_q;
        snap_d      = snap_q;
        sat_d       = sat_q;
        disp_d      = disp_q;
        bcd_d       = bcd_q;
        bitcnt_d    = bitcnt_q;
        flash_cnt_d = flash_cnt_q;
        bcd_adj     = bcd_q;
        in_bit      = 1'b0;

        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
        // MSB-first: bitcnt 0 selects snap[VAL_W-1].
        for (int unsigned i = 0; i < VAL_W; i++) begin
            if (bitcnt_q == CNT_W'(VAL_W - 1 - i)) begin
                in_bit = snap_q[i];
            end
        end

        if (frame_tick && flash_cnt_q != '0) begin
            flash_cnt_d = flash_cnt_q - FL_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (value != shown_bin_q) begin
                    snap_d   = value;
                    sat_d    = 32'(value) > MAX_VAL;
                    bcd_d    = '0;
                    bitcnt_d = '0;
                    state_d  = StConv;
                end
            end
            StConv: begin
                bcd_d    = {bcd_adj[BCD_W-2:0], in_bit};
                bitcnt_d = bitcnt_q + CNT_W'(1);
                if (bitcnt_q == CNT_W'(VAL_W - 1)) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                disp_d      = sat_q ? {DIGITS{4'h9}} : bcd_q;
                shown_bin_d = snap_q;
                flash_cnt_d = FL_W'(FLASH_FRAMES);
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy = (state_q != StIdle);

    logic [DIGITS-1:0] dig_en;
    logic [DIGITS-1:0] dig_vis;
    logic [23:0]       unused_rgb [DIGITS];

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        localparam logic [9:0] XK = H_POS + DIGIT_PITCH * 10'(DIGITS - 1 - k);

        if (!BLANK_LZ || k == 0) begin : g_always_on
            assign dig_en[k] = 1'b1;
        end else begin : g_blank
            assign dig_en[k] = |disp_q[BCD_W-1:4*k];
        end

        single_number #(
            .X_POS (XK),
            .Y_POS (V_POS)
        ) u_digit (
            .hcounter (hcounter),
            .vcounter (vcounter),
            .digit    (disp_q[4*k +: 4]),
            .visible  (dig_vis[k]),
            .rgb      (unused_rgb[k])
        );
    end

    logic        flash_on;
    logic [23:0] colour;

    always_comb begin
        flash_on = (flash_cnt_q != '0) && flash_cnt_q[2];
        colour   = flash_on ? FLASH_COLOR : COLOR;
        visible  = |(dig_en & dig_vis);
        rgb      = visible ? colour : 24'h000000;
    end

endmodule

// Seven-segment glyph, 12x20 pixels with 2-pixel strokes, origin at (X_POS, Y_POS).
// Codes above 9 draw nothing.
module single_number #(
    parameter logic [9:0]  X_POS = 10'd0,
    parameter logic [9:0]  Y_POS = 10'd0,
    parameter logic [23:0] COLOR = 24'hffffff
) (
    input  logic [9:0]  hcounter,
    input  logic [9:0]  vcounter,
    input  logic [3:0]  digit,
    output logic        visible,
    output logic [23:0] rgb
);

    logic [10:0] dx, dy;
    logic [6:0]  seg;
    logic        in_box, top, mid, bot, left, right, upper, lower;

    always_comb begin
        // Pixels left of/above the origin wrap to large offsets and fall outside the box.
        dx = {1'b0, hcounter} - {1'b0, X_POS};
        dy = {1'b0, vcounter} - {1'b0, Y_POS};
        in_box = (dx < 11'd12) && (dy < 11'd20);
        top    = dy <= 11'd1;
        mid    = (dy == 11'd9) || (dy == 11'd10);
        bot    = dy >= 11'd18;
        left   = dx <= 11'd1;
        right  = dx >= 11'd10;
        upper  = dy <= 11'd10;
        lower  = dy >= 11'd9;

        case (digit)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1111011;
            default: seg = 7'b0000000;
        endcase

        visible = in_box && ((seg[6] && top) || (seg[5] && right && upper) ||
                             (seg[4] && right && lower) || (seg[3] && bot) ||
                             (seg[2] && left && lower) || (seg[1] && left && upper) ||
                             (seg[0] && mid));
        rgb = visible ? COLOR : 24'h000000;
    end

endmodule

// File: tb/tb_counter_disp.sv
// Randomised and directed checks of counter_disp (default parameters) against a
// transaction-level model of the displayed number, flash counter and glyph shapes.

module tb_counter_disp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  value = 8'd0;
    logic        frame_tick = 1'b0;
    logic [9:0]  hcounter = 10'd0;
    logic [9:0]  vcounter = 10'd0;
    logic        busy, visible;
    logic [23:0] rgb;

    int n_vec = 0;
    int n_err = 0;

    // Model: the number on screen, the value last committed, the pending conversion.
    int m_shown = 0, m_snap = 0, m_disp = 0, m_flash = 0, m_pending = 0;

    // Segments a..g as bits 6..0, and each segment's rectangle inside the 12x20 cell.
    int segtab[10] = '{'h7E, 'h30, 'h6D, 'h79, 'h33, 'h5B, 'h5F, 'h70, 'h7F, 'h7B};
    int rx0[7] = '{0, 10, 10, 0, 0, 0, 0};
    int rx1[7] = '{11, 11, 11, 11, 1, 1, 11};
    int ry0[7] = '{0, 0, 9, 18, 9, 0, 9};
    int ry1[7] = '{1, 10, 19, 19, 19, 10, 10};

    always #5 clk = ~clk;

    counter_disp dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .frame_tick (frame_tick),
        .hcounter   (hcounter),
        .vcounter   (vcounter),
        .busy       (busy),
        .visible    (visible),
        .rgb        (rgb)
    );

    function automatic bit glyph_px(int d, int px, int py);
        if (d < 0 || d > 9) return 1'b0;
        for (int s = 0; s < 7; s++) begin
            if (((segtab[d] >> (6 - s)) & 1) == 1 && px >= rx0[s] && px <= rx1[s] &&
                py >= ry0[s] && py <= ry1[s]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Units digit at x=60, tens at x=40, tens blanked while the number is below 10.
    function automatic bit exp_vis(int h, int v);
        return glyph_px(m_disp % 10, h - 60, v - 80) ||
               (m_disp >= 10 && glyph_px(m_disp / 10, h - 40, v - 80));
    endfunction

    function automatic logic [23:0] exp_rgb(int h, int v);
        if (!exp_vis(h, v)) return 24'h000000;
        return (m_flash != 0 && (m_flash % 8) >= 4) ? 24'hffffff : 24'h00ff00;
    endfunction

    function automatic void model_reset();
        m_shown = 0; m_snap = 0; m_disp = 0; m_flash = 0; m_pending = 0;
    endfunction

    // One clock edge: apply it to the model with the inputs held across the edge.
    task automatic step();
        int v;
        bit t;
        v = int'(value);
        t = frame_tick;
        @(posedge clk);
        if (rst_n) begin
            if (m_pending == 0) begin
                if (t && m_flash > 0) m_flash--;
                if (v != m_shown) begin
                    m_snap = v;
                    m_pending = 9;
                end
            end else begin
                m_pending--;
                if (m_pending == 0) begin
                    m_shown = m_snap;
                    m_disp  = (m_snap > 99) ? 99 : m_snap;
                    m_flash = 32;
                end else if (t && m_flash > 0) begin
                    m_flash--;
                end
            end
        end
        #1;
    endtask

    task automatic probe(input int h, input int v);
        hcounter = 10'(h);
        vcounter = 10'(v);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        value = 8'd0;
        model_reset();
        #3;
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL reset_busy got %b want 0", busy);
        end
        for (int h = 36; h <= 76; h++) begin
            for (int v = 76; v <= 103; v++) begin
                probe(h, v);
                n_vec++;
                if (visible !== exp_vis(h, v) || rgb !== exp_rgb(h, v)) begin
                    n_err++;
                    $display("FAIL reset_pixel (%0d,%0d) got vis=%b rgb=%h want vis=%b rgb=%h",
                             h, v, visible, rgb, exp_vis(h, v), exp_rgb(h, v));
                end
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++;
            if (busy !== 1'b0) begin
                n_err++; $display("FAIL idle_busy cycle %0d got %b want 0", i, busy);
            end
        end
    endtask

    task automatic test_convert();
        int cnt;
        cnt = 0;
        value = 8'd42;
        for (int i = 0; i < 12; i++) begin
            step();
            n_vec++;
            if (busy !== (m_pending != 0)) begin
                n_err++; $display("FAIL conv_busy cycle %0d got %b want %b", i, busy, m_pending != 0);
            end
            cnt += int'(busy);
        end
        n_vec++;
        if (cnt !== 9) begin
            n_err++; $display("FAIL conv_busy_len got %0d want 9", cnt);
        end
        for (int h = 36; h <= 76; h++) begin
            for (int v = 76; v <= 103; v++) begin
                probe(h, v);
                n_vec++;
                if (visible !== exp_vis(h, v) || rgb !== exp_rgb(h, v)) begin
                    n_err++;
                    $display("FAIL conv42_pixel (%0d,%0d) got vis=%b rgb=%h want vis=%b rgb=%h",
                             h, v, visible, rgb, exp_vis(h, v), exp_rgb(h, v));
                end
            end
        end
        probe(40, 82); n_vec++;
        if (visible !== 1'b1) begin n_err++; $display("FAIL tens4_f got %b want 1", visible); end
        probe(60, 95); n_vec++;
        if (visible !== 1'b1) begin n_err++; $display("FAIL units2_e got %b want 1", visible); end
        probe(45, 80); n_vec++;
        if (visible !== 1'b0) begin n_err++; $display("FAIL tens4_no_a got %b want 0", visible); end
    endtask

    task automatic test_saturation();
        value = 8'd200;
        for (int i = 0; i < 12; i++) step();
        for (int i = 0; i < 20; i++) begin
            step();
            n_vec++;
            if (busy !== 1'b0) begin
                n_err++; $display("FAIL sat_reconv cycle %0d got busy=%b want 0", i, busy);
            end
        end
        probe(45, 89); n_vec++;
        if (visible !== 1'b1) begin n_err++; $display("FAIL sat_tens9_g got %b want 1", visible); end
        probe(40, 95); n_vec++;
        if (visible !== 1'b0) begin n_err++; $display("FAIL sat_tens9_no_e got %b want 0", visible); end
        for (int h = 36; h <= 76; h += 2) begin
            for (int v = 76; v <= 103; v++) begin
                probe(h, v);
                n_vec++;
                if (visible !== exp_vis(h, v)) begin
                    n_err++;
                    $display("FAIL sat_pixel (%0d,%0d) got %b want %b", h, v, visible, exp_vis(h, v));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        value = 8'd5;
        for (int i = 0; i < 12; i++) step();
        value = 8'd42;
        for (int i = 0; i < 3; i++) step();   // E0..E2
        value = 8'd7;
        for (int i = 3; i <= 9; i++) begin
            step();
            n_vec++;
            if (busy !== (m_pending != 0)) begin
                n_err++; $display("FAIL b2b_busy E%0d got %b want %b", i, busy, m_pending != 0);
            end
        end
        probe(40, 82); n_vec++;
        if (visible !== 1'b1) begin n_err++; $display("FAIL b2b_first42 got %b want 1", visible); end
        step();
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_redetect got %b want 1", busy); end
        for (int i = 0; i < 9; i++) step();
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_done got %b want 0", busy); end
        probe(40, 82); n_vec++;
        if (visible !== 1'b0) begin n_err++; $display("FAIL b2b_lz_blank got %b want 0", visible); end
        for (int h = 36; h <= 76; h++) begin
            for (int v = 76; v <= 103; v += 3) begin
                probe(h, v);
                n_vec++;
                if (visible !== exp_vis(h, v)) begin
                    n_err++;
                    $display("FAIL b2b_pixel (%0d,%0d) got %b want %b", h, v, visible, exp_vis(h, v));
                end
            end
        end
    endtask

    task automatic test_flash();
        probe(62, 80);
        for (int i = 0; i < 36; i++) begin
            n_vec++;
            if (rgb !== exp_rgb(62, 80)) begin
                n_err++;
                $display("FAIL flash_rgb tick %0d got %h want %h", i, rgb, exp_rgb(62, 80));
            end
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
        end
        n_vec++;
        if (rgb !== 24'h00ff00) begin n_err++; $display("FAIL flash_end got %h want 00ff00", rgb); end
        // Tick landing on the commit edge must not eat into the fresh flash count.
        value = 8'd9;
        for (int i = 0; i < 20 && m_pending != 1; i++) step();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        n_vec++;
        if (rgb !== 24'h00ff00) begin
            n_err++; $display("FAIL flash_coincident got %h want 00ff00", rgb);
        end
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        n_vec++;
        if (rgb !== 24'hffffff) begin
            n_err++; $display("FAIL flash_first_tick got %h want ffffff", rgb);
        end
    endtask

    task automatic test_reset_midconv();
        int cnt;
        value = 8'd13;
        for (int i = 0; i < 5; i++) step();   // E0..E4
        rst_n = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
        for (int h = 36; h <= 76; h += 2) begin
            for (int v = 76; v <= 103; v++) begin
                probe(h, v);
                n_vec++;
                if (visible !== exp_vis(h, v) || rgb !== exp_rgb(h, v)) begin
                    n_err++;
                    $display("FAIL rst_pixel (%0d,%0d) got vis=%b rgb=%h want vis=%b rgb=%h",
                             h, v, visible, rgb, exp_vis(h, v), exp_rgb(h, v));
                end
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 11; i++) begin
            step();
            cnt += int'(busy);
        end
        n_vec++;
        if (cnt !== 9) begin n_err++; $display("FAIL rst_conv_len got %0d want 9", cnt); end
        probe(70, 82); n_vec++;
        if (visible !== 1'b1) begin n_err++; $display("FAIL rst_units3_b got %b want 1", visible); end
        probe(50, 82); n_vec++;
        if (visible !== 1'b1) begin n_err++; $display("FAIL rst_tens1_b got %b want 1", visible); end
        probe(40, 82); n_vec++;
        if (visible !== 1'b0) begin n_err++; $display("FAIL rst_tens1_no_f got %b want 0", visible); end
        probe(60, 80); n_vec++;
        if (rgb !== 24'h00ff00) begin n_err++; $display("FAIL rst_colour got %h want 00ff00", rgb); end
    endtask

    task automatic test_random();
        int h, v;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) value = 8'($urandom_range(0, 255));
            frame_tick = ($urandom_range(0, 3) == 0);
            step();
            frame_tick = 1'b0;
            n_vec++;
            if (busy !== (m_pending != 0)) begin
                n_err++; $display("FAIL rand_busy cycle %0d got %b want %b", i, busy, m_pending != 0);
            end
            h = int'($urandom_range(36, 76));
            v = int'($urandom_range(76, 103));
            probe(h, v);
            n_vec++;
            if (visible !== exp_vis(h, v) || rgb !== exp_rgb(h, v)) begin
                n_err++;
                $display("FAIL rand_pixel cycle %0d (%0d,%0d) got vis=%b rgb=%h want vis=%b rgb=%h",
                         i, h, v, visible, rgb, exp_vis(h, v), exp_rgb(h, v));
            end
        end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_saturation();
        test_back_to_back();
        test_flash();
        test_reset_midconv();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
